te_sample_decimator: RTL and testbench

- Input-conditioning stage directly upstream of the tracking-engine sample FIFO.
- Takes raw signed I/Q ADC samples and runs an accumulate-and-dump decimator over N samples, N = 1..32.
- Rounds, shifts and saturates each sum, then packs I/Q into one byte.
- Presents the byte on the FIFO's sample_valid/sample_data input pair and counts saturation events for firmware.

---
 rtl/te_sample_decimator.sv | 130 +++++++++++++
 tb/tb_te_sample_decimator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_sample_decimator.sv
// Accumulate-and-dump I/Q decimator feeding the tracking-engine sample FIFO.
// Sums N raw samples, rounds/shifts/saturates each sum and packs {I,Q} into one word.
module te_sample_decimator #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4,
  parameter int ACC_WIDTH = IN_WIDTH + 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [4:0]                  dec_ratio,
  input  logic [3:0]                  out_shift,
  input  logic                        phase_sync,
  input  logic                        adc_valid,
  input  logic signed [IN_WIDTH-1:0]  adc_i,
  input  logic signed [IN_WIDTH-1:0]  adc_q,
  output logic                        sample_valid,
  output logic [2*OUT_WIDTH-1:0]      sample_data,
  input  logic                        sat_clear,
  output logic [15:0]                 sat_count
);

  localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

  // Round half up then arithmetic shift; oversize shifts clamp to ACC_WIDTH-1.
  function automatic logic signed [ACC_WIDTH:0] rnd_shift(
    input logic signed [ACC_WIDTH-1:0] sum,
    input logic [3:0]                  sh
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] half;
    int s;
    s = int'(sh);
    if (s >= ACC_WIDTH) s = ACC_WIDTH - 1;
    ext = {sum[ACC_WIDTH-1], sum};
    if (s == 0) return ext;
    half = (ACC_WIDTH+1)'(1) << (s - 1);
    return (ext + half) >>> s;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] clip(input logic signed [ACC_WIDTH:0] r);
    if (r > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    if (r < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    return r[OUT_WIDTH-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [ACC_WIDTH:0] r);
    return (r > OUT_MAX) || (r < OUT_MIN);
  endfunction

  logic [4:0]                  cnt;
  logic [4:0]                  ratio_l;
  logic [4:0]                  pos;
  logic [4:0]                  ratio_eff;
  logic                        grp_first;
  logic                        dump;
  logic signed [ACC_WIDTH-1:0] smp_i, smp_q;
  logic signed [ACC_WIDTH-1:0] nxt_i, nxt_q;
  logic signed [ACC_WIDTH-1:0] acc_i_p0, acc_q_p0;
  logic signed [ACC_WIDTH-1:0] sum_i_p1, sum_q_p1;
  logic                        vld_p1;
  logic signed [ACC_WIDTH:0]   rnd_i_p2, rnd_q_p2;
  logic                        word_sat;

  // A phase_sync sample opens a new group, so it behaves exactly like cnt==0.
  assign grp_first = phase_sync || (cnt == '0);
  assign pos       = grp_first ? '0 : cnt;
  assign ratio_eff = grp_first ? dec_ratio : ratio_l;
  assign dump      = enable && adc_valid && (pos == ratio_eff);
  assign smp_i     = {{(ACC_WIDTH-IN_WIDTH){adc_i[IN_WIDTH-1]}}, adc_i};
  assign smp_q     = {{(ACC_WIDTH-IN_WIDTH){adc_q[IN_WIDTH-1]}}, adc_q};
  assign nxt_i     = grp_first ? smp_i : acc_i_p0 + smp_i;
  assign nxt_q     = grp_first ? smp_q : acc_q_p0 + smp_q;

  // Stage 0/1: accumulate, dump the closing sum into stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      ratio_l  <= '0;
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
      sum_i_p1 <= '0;
      sum_q_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= dump;
      if (adc_valid) begin
        if (grp_first) ratio_l <= dec_ratio;
        acc_i_p0 <= nxt_i;
        acc_q_p0 <= nxt_q;
        if (dump) begin
          cnt      <= '0;
          sum_i_p1 <= nxt_i;
          sum_q_p1 <= nxt_q;
        end else begin
          cnt <= pos + 5'd1;
        end
      end else if (phase_sync) begin
        cnt <= '0;
      end
    end
  end

  assign rnd_i_p2 = rnd_shift(sum_i_p1, out_shift);
  assign rnd_q_p2 = rnd_shift(sum_q_p1, out_shift);
  assign word_sat = is_sat(rnd_i_p2) || is_sat(rnd_q_p2);

  // Stage 2: round, saturate, pack and count clipped words
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sat_count    <= '0;
    end else begin
      sample_valid <= vld_p1 && enable;
      if (vld_p1 && enable) sample_data <= {clip(rnd_i_p2), clip(rnd_q_p2)};
      if (sat_clear)
        sat_count <= '0;
      else if (vld_p1 && enable && word_sat && (sat_count != 16'hFFFF))
        sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_te_sample_decimator.sv
// Bench for te_sample_decimator: directed vector table, corner-case sequences,
// then randomized traffic against a queue-based group model.
module tb_te_sample_decimator;
  localparam int IW = 4;
  localparam int OW = 4;
  localparam int AW = IW + 5;

  logic                 clk = 1'b0;
  logic                 rst, enable, phase_sync, adc_valid, sat_clear;
  logic [4:0]           dec_ratio;
  logic [3:0]           out_shift;
  logic signed [IW-1:0] adc_i, adc_q;
  logic                 sample_valid;
  logic [2*OW-1:0]      sample_data;
  logic [15:0]          sat_count;

  always #5 clk = ~clk;

  te_sample_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dec_ratio(dec_ratio), .out_shift(out_shift),
    .phase_sync(phase_sync), .adc_valid(adc_valid), .adc_i(adc_i), .adc_q(adc_q),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sat_clear(sat_clear), .sat_count(sat_count)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic exp3(input string tag, input int v, input int d, input int s);
    chk({tag, ".valid"}, int'(sample_valid), v);
    chk({tag, ".data"},  int'(sample_data),  d);
    chk({tag, ".sat"},   int'(sat_count),    s);
  endtask

  // Reference model: groups are lists of samples, outputs use plain integer math.
  int g_i[$];
  int g_q[$];
  int g_n = 1;
  bit p1_have = 0;
  int p1_si = 0, p1_sq = 0;
  bit m_valid = 0;
  int m_data = 0, m_sat = 0;

  function automatic int fdiv(input int a, input int d);
    int qv;
    qv = a / d;
    if ((a % d != 0) && (a < 0)) qv--;
    return qv;
  endfunction

  function automatic int rshift(input int sum, input int sh);
    int s;
    s = (sh > AW - 1) ? AW - 1 : sh;
    if (s == 0) return sum;
    return fdiv(sum + (1 << (s - 1)), 1 << s);
  endfunction

  function automatic int clipv(input int r);
    int hi, lo;
    hi = (1 << (OW - 1)) - 1;
    lo = -(1 << (OW - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  task automatic model_step();
    int ri, rq, ci, cq, si, sq, mask;
    bit nv;
    ri = 0; rq = 0; ci = 0; cq = 0;
    mask = (1 << OW) - 1;
    if (rst) begin
      g_i.delete(); g_q.delete();
      p1_have = 0; m_valid = 0; m_data = 0; m_sat = 0;
      return;
    end
    nv = p1_have && enable;
    if (nv) begin
      ri = rshift(p1_si, int'(out_shift));
      rq = rshift(p1_sq, int'(out_shift));
      ci = clipv(ri);
      cq = clipv(rq);
      m_data = ((ci & mask) << OW) | (cq & mask);
    end
    if (sat_clear) m_sat = 0;
    else if (nv && (ci != ri || cq != rq) && m_sat < 65535) m_sat++;
    m_valid = nv;
    p1_have = 0;
    if (!enable) begin
      g_i.delete(); g_q.delete();
    end else begin
      if (phase_sync) begin
        g_i.delete(); g_q.delete();
      end
      if (adc_valid) begin
        if (g_i.size() == 0) g_n = int'(dec_ratio) + 1;
        g_i.push_back(int'(adc_i));
        g_q.push_back(int'(adc_q));
        if (g_i.size() == g_n) begin
          si = 0; sq = 0;
          foreach (g_i[k]) begin
            si += g_i[k];
            sq += g_q[k];
          end
          p1_si = si; p1_sq = sq; p1_have = 1;
          g_i.delete(); g_q.delete();
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input bit av, input int i, input int q);
    adc_valid = av;
    adc_i = 4'(i);
    adc_q = 4'(q);
  endtask

  typedef struct {
    logic rst, en;
    logic [4:0] ratio;
    logic [3:0] shift;
    logic ps, av;
    logic signed [IW-1:0] i, q;
    logic clr, ev;
    logic [7:0] ed;
    logic [15:0] es;
  } vec_t;

  function automatic vec_t mk(input int r, input int en, input int ratio, input int sh,
                              input int ps, input int av, input int i, input int q,
                              input int clr, input int ev, input int ed, input int es);
    vec_t v;
    v.rst = r[0]; v.en = en[0]; v.ratio = ratio[4:0]; v.shift = sh[3:0];
    v.ps = ps[0]; v.av = av[0]; v.i = i[3:0]; v.q = q[3:0];
    v.clr = clr[0]; v.ev = ev[0]; v.ed = ed[7:0]; v.es = es[15:0];
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    rst = 1'b1; enable = 1'b1; dec_ratio = 5'd0; out_shift = 4'd0;
    phase_sync = 1'b0; sat_clear = 1'b0; drv(0, 0, 0);

    // rst en ratio sh ps av i q clr | valid data sat
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, -2, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h3E, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h3E, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 1, 3, 2, 0, 1, 5, -3, 0, 0, 'h3E, 0));
    tbl.push_back(mk(0, 1, 3, 2, 0, 0, 0, 0, 0, 1, 'h5D, 0));
    tbl.push_back(mk(0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 'h5D, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 1, 3, 0, 0, 1, 7, -8, 0, 0, 'h5D, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 'h78, 1));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 'h78, 1));

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; enable = tbl[k].en; dec_ratio = tbl[k].ratio;
      out_shift = tbl[k].shift; phase_sync = tbl[k].ps; adc_valid = tbl[k].av;
      adc_i = tbl[k].i; adc_q = tbl[k].q; sat_clear = tbl[k].clr;
      cyc();
      exp3($sformatf("vec%0d", k), int'(tbl[k].ev), int'(tbl[k].ed), int'(tbl[k].es));
    end

    // Three more saturating groups, then sat_clear on the edge of the fifth word
    dec_ratio = 5'd3; out_shift = 4'd0;
    for (int g = 0; g < 4; g++) begin
      drv(1, 7, -8);
      for (int k = 0; k < 4; k++) cyc();
      drv(0, 0, 0);
      sat_clear = (g == 3);
      cyc();
      exp3($sformatf("satgrp%0d", g), 1, 'h78, (g == 3) ? 0 : g + 2);
      sat_clear = 1'b0;
    end
    cyc();
    exp3("sat_after_clear", 0, 'h78, 0);

    // phase_sync restarts the group mid-way
    drv(1, 1, 1);
    for (int k = 0; k < 6; k++) begin
      phase_sync = (k == 2);
      cyc();
      chk($sformatf("sync_nopulse%0d", k), int'(sample_valid), 0);
    end
    phase_sync = 1'b0;
    drv(0, 0, 0);
    cyc();
    exp3("sync_word", 1, 'h44, 0);

    // Continuous N=1 stream with a one-cycle enable drop
    dec_ratio = 5'd0;
    for (int c = 0; c < 5; c++) begin
      drv(1, c + 1, -(c + 1));
      enable = (c != 3);
      cyc();
      case (c)
        0: chk("stream0.valid", int'(sample_valid), 0);
        1: exp3("stream1", 1, 'h1F, 0);
        2: exp3("stream2", 1, 'h2E, 0);
        3: exp3("stream3", 0, 'h2E, 0);
        default: exp3("stream4", 0, 'h2E, 0);
      endcase
    end
    drv(0, 0, 0);
    cyc();
    exp3("stream_resume", 1, 'h5B, 0);
    cyc();
    chk("stream_idle.valid", int'(sample_valid), 0);

    // rst in the middle of a group
    dec_ratio = 5'd1;
    drv(1, 7, 7); cyc(); cyc();
    drv(0, 0, 0); cyc();
    exp3("presat", 1, 'h77, 1);
    dec_ratio = 5'd3;
    drv(1, 1, 1); cyc(); cyc();
    rst = 1'b1; cyc();
    exp3("mid_rst", 0, 'h00, 0);
    rst = 1'b0;
    drv(1, 1, -1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("post_rst_nopulse%0d", k), int'(sample_valid), 0);
    end
    drv(0, 0, 0); cyc();
    exp3("post_rst_word", 1, 'h4C, 0);

    // dec_ratio change mid-group applies only from the next group
    dec_ratio = 5'd3;
    drv(1, 1, 1);
    for (int k = 0; k < 7; k++) begin
      if (k == 1) dec_ratio = 5'd1;
      if (k == 6) drv(0, 0, 0);
      cyc();
      case (k)
        4: exp3("ratio_g1", 1, 'h44, 0);
        6: exp3("ratio_g2", 1, 'h22, 0);
        default: chk($sformatf("ratio_nopulse%0d", k), int'(sample_valid), 0);
      endcase
    end

    // Randomized traffic against the model
    rst = 1'b1; drv(0, 0, 0); cyc();
    rst = 1'b0; enable = 1'b1; phase_sync = 1'b0; sat_clear = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0)
        dec_ratio = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      out_shift = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      phase_sync = ($urandom_range(0, 39) == 0);
      sat_clear = ($urandom_range(0, 63) == 0);
      drv($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      cyc();
      chk("rnd.valid", int'(sample_valid), int'(m_valid));
      chk("rnd.data",  int'(sample_data),  m_data);
      chk("rnd.sat",   int'(sat_count),    m_sat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
